multiword_add_seq: RTL

//   Sequencer that performs WIDTH*WORDS-bit addition on one external WIDTH-bit ripple-carry adder slice.

---
 rtl/multiword_add_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: drives one external WIDTH-bit adder slice for WORDS cycles, LSB slice first.
// Optional feature: define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module multiword_add_seq #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] op_a,
    input  logic [WIDTH*WORDS-1:0] op_b,
    input  logic                   op_cin,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] result,
    output logic                   result_cout,
    output logic                   busy
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                   ovf
`endif
);

    localparam int N     = WIDTH * WORDS;
    localparam int CTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CTR_W-1:0] ctr;
    logic             carry;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic             accept;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last      = (ctr == CTR_W'(WORDS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Slice selection toward the adder; quiet (all zero) outside RUN.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_cin = carry;
            for (int i = 0; i < WORDS; i++) begin
                if (ctr == CTR_W'(i)) begin
                    add_a = a_reg[i*WIDTH +: WIDTH];
                    add_b = b_reg[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before RUN reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= op_a;
            b_reg <= op_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr         <= '0;
            carry       <= 1'b0;
            result      <= '0;
            result_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry <= op_cin;
                        ctr   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (ctr == CTR_W'(i)) begin
                            result[i*WIDTH +: WIDTH] <= add_sum;
                        end
                    end
                    carry <= add_cout;
                    if (last) begin
                        result_cout <= add_cout;
                        ctr         <= '0;
                    end else begin
                        ctr <= ctr + CTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OVERFLOW_FLAG_EN
    // Signed overflow: like-signed operands producing a sum of the opposite sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last) begin
            ovf <= (a_reg[N-1] == b_reg[N-1]) && (add_sum[WIDTH-1] != a_reg[N-1]);
        end
    end
`endif

endmodule
